// File: rtl/serial_subtractor16.sv
// serial_subtractor16: digit-serial unsigned subtractor, {b_out, diff} = a - b.
// Operands are captured on an in_valid/in_ready handshake, then processed DIGIT
// bits per clock, LSB digit first, with a rippling borrow register. The result
// is held on out_valid until out_ready accepts it.
// Optional feature: define SUB_OVF_EN to add the signed-overflow output ovf.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer keeps valid and data stable until
// that edge. in_ready is high only in IDLE and out_valid only in DONE, so at
// most one operation is in flight.
//
// DIGIT must divide WIDTH (1, 2, 4, 8 or 16 for WIDTH=16).
module serial_subtractor16 #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic [1:0]       dbg_state
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG  = WIDTH / DIGIT;
  // +1 keeps the counter at least one bit wide when NDIG == 1.
  localparam int CNT_W = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic               borrow;
  logic [CNT_W-1:0]   cnt;

  logic [DIGIT:0]     dig_sub;
  logic [DIGIT-1:0]   dig_res;
  logic               dig_borrow;
  logic               last_digit;
`ifdef SUB_OVF_EN
  logic               ovf_next;
`endif

  assign dbg_state = state;

  // One digit of subtraction on the low bits of the operand shift registers.
  // The extra top bit of dig_sub goes high exactly when the digit result is
  // negative, which is the borrow to the next digit.
  always_comb begin
    dig_sub    = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
                 - {{DIGIT{1'b0}}, borrow};
    dig_res    = dig_sub[DIGIT-1:0];
    dig_borrow = dig_sub[DIGIT];
    last_digit = (cnt == CNT_W'(NDIG - 1));
  end

`ifdef SUB_OVF_EN
  // Signed overflow of a - b: operand signs differ and the result sign differs
  // from the minuend. This equals borrow-into-MSB XOR borrow-out-of-MSB.
  always_comb begin
    ovf_next = (a_sh[DIGIT-1] ^ b_sh[DIGIT-1]) & (dig_res[DIGIT-1] ^ a_sh[DIGIT-1]);
  end
`endif

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      b_out     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
`ifdef SUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            borrow   <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          // Result digits enter at the MSB end, so after NDIG digits the
          // first (least significant) digit has reached the bottom of diff.
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          diff   <= WIDTH'({dig_res, diff} >> DIGIT);
          borrow <= dig_borrow;
          cnt    <= cnt + CNT_W'(1);
          if (last_digit) begin
            b_out     <= dig_borrow;
`ifdef SUB_OVF_EN
            ovf       <= ovf_next;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // Result stays frozen until the consumer takes it.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor16.sv
// tb_serial_subtractor16: directed bench for serial_subtractor16 (WIDTH=16, DIGIT=1).
module tb_serial_subtractor16;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         b_out;
  logic [1:0]   dbg_state;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  logic [W:0] exp_q[$];

  serial_subtractor16 #(.WIDTH(W), .DIGIT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .dbg_state (dbg_state)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, wait for the result (bounded), return it with
  // the number of edges between accept and out_valid. The model value is
  // pushed on the expected queue.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        output logic [W:0] res, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    a        = oa;
    b        = ob;
    in_valid = 1'b1;
    exp_q.push_back({1'b0, oa} - {1'b0, ob});
    tick();
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    res = {b_out, diff};
  endtask

  // Compare a result with the head of the expected queue.
  task automatic sb_check(input string tag, input logic [W:0] res);
    logic [W:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1_DEAD;
    check(tag, res, e);
  endtask

  logic [W:0]   res;
  int           lat;
  logic [W-1:0] vals[16];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    tick();
    tick();

    // Reset state
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff",      diff,      0);
    check("rst_b_out",     b_out,     0);
    check("rst_state",     dbg_state, 0);
`ifdef SUB_OVF_EN
    check("rst_ovf",       ovf,       0);
`endif
    rst = 1'b0;
    tick();

    // 5 - 3 = 2, latency 16
    run_op(16'd5, 16'd3, res, lat);
    check("lat_5_3",       lat,       16);
    check("res_5_3",       res,       17'h0_0002);
    check("done_state",    dbg_state, 2);
    check("done_in_ready", in_ready,  0);
    sb_check("sb_5_3", res);
    tick();
    check("hs_out_valid",  out_valid, 0);
    check("hs_in_ready",   in_ready,  1);

    // 3 - 5 wraps with borrow
    run_op(16'd3, 16'd5, res, lat);
    check("res_3_5", res, 17'h1_FFFE);
    sb_check("sb_3_5", res);
    tick();

    // 0 - 1
    run_op(16'd0, 16'd1, res, lat);
    check("res_0_1", res, 17'h1_FFFF);
    sb_check("sb_0_1", res);
    tick();

    // FFFF - FFFF
    run_op(16'hFFFF, 16'hFFFF, res, lat);
    check("res_ff_ff", res, 17'h0_0000);
    sb_check("sb_ff_ff", res);
    tick();

    // Backpressure: hold out_ready low for 10 cycles in DONE while a new
    // operand pair is offered.
    out_ready = 1'b0;
    run_op(16'd1000, 16'd1, res, lat);
    check("bp_res", res, 17'h0_03E7);
    sb_check("sb_bp", res);
    a        = 16'd7;
    b        = 16'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_diff",      diff,      16'h03E7);
      check("bp_b_out",     b_out,     0);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready",  in_ready,  0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready,  1);
    check("bp_release_state", dbg_state, 0);

    // Reset during the 8th RUN cycle aborts the operation.
    a        = 16'd1234;
    b        = 16'd4321;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("mid_state", dbg_state, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready",  in_ready,  1);
    check("abort_diff",      diff,      0);
    check("abort_b_out",     b_out,     0);
    run_op(16'd100, 16'd1, res, lat);
    check("res_100_1", res, 17'h0_0063);
    check("lat_100_1", lat, 16);
    sb_check("sb_100_1", res);
    tick();

`ifdef SUB_OVF_EN
    run_op(16'h8000, 16'h0001, res, lat);
    check("ovf_res_8000_1", res, 17'h0_7FFF);
    check("ovf_8000_1",     ovf, 1);
    sb_check("sb_8000_1", res);
    tick();
    run_op(16'h0001, 16'h0002, res, lat);
    check("ovf_res_1_2", res, 17'h1_FFFF);
    check("ovf_1_2",     ovf, 0);
    sb_check("sb_1_2", res);
    tick();
`endif

    // Corner sweep over the low and high ends of the operand range.
    for (int i = 0; i < 8; i++) begin
      vals[i]     = 16'(i);
      vals[i + 8] = 16'(65528 + i);
    end
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [W:0] e;
        run_op(vals[i], vals[j], res, lat);
        e = exp_q.pop_front();
        checks++;
        assert (res === e) else begin
          errors++;
          $error("FAIL sweep t=%0t a=%0h b=%0h observed=%0h expected=%0h",
                 $time, vals[i], vals[j], res, e);
        end
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
